// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the floating-point add arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } fp_arb_state_t;

    localparam int   FP_WIDTH  = 32;
    localparam logic FP_OP_ADD = 1'b0;
    localparam logic FP_OP_SUB = 1'b1;

endpackage

// File: rtl/floating_unit.sv
// Single-precision add/subtract, round-to-nearest-even; denormal/NaN/Inf get no special treatment.
// Latency: purely combinational.
// Backpressure: none.
module floating_unit
    import fp_arb_pkg::*;
(
    input  logic [FP_WIDTH-1:0] a,
    input  logic [FP_WIDTH-1:0] b,
    input  logic                op,
    output logic [FP_WIDTH-1:0] y
);

    logic               sa, sb, sh, sl, swap, stk, rnd_up;
    logic [7:0]         ea, eb, eh, el, d;
    logic [23:0]        ma, mb, mh, ml;
    logic [4:0]         dsh, lz;
    logic [53:0]        al_wide;
    logic [26:0]        ml_al, nrm;
    logic [27:0]        sum;
    logic [24:0]        mr;
    logic signed [9:0]  er, ef;

    always_comb begin
        sa   = a[31];
        sb   = b[31] ^ (op == FP_OP_SUB);
        ea   = a[30:23];
        eb   = b[30:23];
        ma   = {|ea, a[22:0]};
        mb   = {|eb, b[22:0]};
        swap = {eb, mb} > {ea, ma};
        eh   = swap ? eb : ea;
        el   = swap ? ea : eb;
        mh   = swap ? mb : ma;
        ml   = swap ? ma : mb;
        sh   = swap ? sb : sa;
        sl   = swap ? sa : sb;

        // Align the smaller operand; everything shifted past the round bit folds into sticky.
        d       = eh - el;
        dsh     = (d > 8'd27) ? 5'd27 : d[4:0];
        al_wide = {ml, 3'b000, 27'd0} >> dsh;
        stk     = |al_wide[26:0];
        ml_al   = {al_wide[53:28], al_wide[27] | stk};

        if (sh == sl)
            sum = {1'b0, mh, 3'b000} + {1'b0, ml_al};
        else
            sum = {1'b0, mh, 3'b000} - {1'b0, ml_al};

        lz = '0;
        for (int i = 0; i < 27; i++) begin
            if (sum[i])
                lz = 5'(26 - i);
        end

        if (sum[27]) begin
            nrm = {sum[27:2], sum[1] | sum[0]};
            er  = $signed({2'b00, eh}) + 10'sd1;
        end else begin
            nrm = sum[26:0] << lz;
            er  = $signed({2'b00, eh}) - $signed({5'b00000, lz});
        end

        rnd_up = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
        mr     = {1'b0, nrm[26:3]} + {24'd0, rnd_up};
        ef     = mr[24] ? er + 10'sd1 : er;

        if (!(mr[24] | mr[23]))
            y = '0;
        else if (ef >= 10'sd255)
            y = {sh, 8'hFF, 23'd0};
        else if (ef <= 10'sd0)
            y = {sh, 31'd0};
        else
            y = {sh, ef[7:0], (mr[24] ? 23'd0 : mr[22:0])};
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or after ptr, searched circularly.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    logic [ID_W-1:0] pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = 0; k < N; k++) begin
            pos = ID_W'((int'(ptr) + k) % N);
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one floating_unit among N_REQ requesters; optional stall counter under FP_ARB_STALL_CNT_EN.
// Latency: grant cycle -> EXEC -> RESP, rsp_valid two cycles after the grant; one op in flight.
// Backpressure: rsp_data/rsp_id held in RESP until rsp_ready; req_ready stays low outside IDLE.
module fp_add_arbiter
    import fp_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = FP_WIDTH,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]       req_sub,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
`ifdef FP_ARB_STALL_CNT_EN
    output logic [15:0]            stall_cnt,
`endif
    output logic [WIDTH-1:0]       rsp_data
);

    fp_arb_state_t   state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] op_id;
    logic [WIDTH-1:0] op_a, op_b, fu_y;
    logic            op_sub;
    logic [N_REQ-1:0] arb_gnt;
    logic [ID_W-1:0] arb_idx;
    logic            arb_any;

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign req_ready = (state == IDLE) ? arb_gnt : '0;

    floating_unit u_fu (
        .a  (op_a),
        .b  (op_b),
        .op (op_sub),
        .y  (fu_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_sub    <= 1'b0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        op_a   <= req_a[arb_idx*WIDTH +: WIDTH];
                        op_b   <= req_b[arb_idx*WIDTH +: WIDTH];
                        op_sub <= req_sub[arb_idx];
                        op_id  <= arb_idx;
                        // Next search starts just past the winner so everyone gets a turn.
                        rr_ptr <= (arb_idx == ID_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= fu_y;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FP_ARB_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (state == RESP && !rsp_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: expected responses queued at stimulus time, checked by an output monitor.
module tb_fp_add_arbiter;
    import fp_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid, req_ready, req_sub;
    logic [N*W-1:0]   req_a, req_b;
    logic             rsp_valid, rsp_ready;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_data;
`ifdef FP_ARB_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    int          nvec = 0;
    int          nerr = 0;
    logic [33:0] sbq[$];
    logic [33:0] exp_e;

    always #5 clk = ~clk;

    fp_add_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
`ifdef FP_ARB_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .rsp_data  (rsp_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic setr(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_sub[i]      = s;
        req_valid[i]    = 1'b1;
    endtask

    task automatic push(input int id, input logic [31:0] d);
        sbq.push_back({2'(id), d});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for any grant, checks it is the expected one, then steps past the accept edge.
    task automatic grant(input string name, input logic [N-1:0] exp_gnt);
        int t;
        t = 0;
        @(negedge clk);
        while (req_ready == '0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk(name, 32'(req_ready), 32'(exp_gnt));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(sbq.size()), 32'd0);
        tick(1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_rsp: got id %0d data %h, expected no response", rsp_id, rsp_data);
                end else begin
                    exp_e = sbq.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(exp_e[33:32]));
                    chk("rsp_data", rsp_data, exp_e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        req_valid = '0;
        req_sub   = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // All four requesters valid from reset: x + 1.0 for x = 1,2,3,4
        setr(0, 32'h3F800000, 32'h3F800000, FP_OP_ADD);
        setr(1, 32'h40000000, 32'h3F800000, FP_OP_ADD);
        setr(2, 32'h40400000, 32'h3F800000, FP_OP_ADD);
        setr(3, 32'h40800000, 32'h3F800000, FP_OP_ADD);
        push(0, 32'h40000000);
        push(1, 32'h40400000);
        push(2, 32'h40800000);
        push(3, 32'h40A00000);
        push(0, 32'h40000000);
        tick(3);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        grant("rr_g0", 4'b0001);
        grant("rr_g1", 4'b0010);
        grant("rr_g2", 4'b0100);
        grant("rr_g3", 4'b1000);
        grant("rr_g4", 4'b0001);
        req_valid = '0;
        drain();

        // Single request and its latency
        setr(0, 32'h40000000, 32'h40000000, FP_OP_ADD);
        push(0, 32'h40800000);
        grant("single_g", 4'b0001);
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("exec_vld", 32'(rsp_valid), 32'd0);
        chk("exec_rdy", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("resp_vld", 32'(rsp_valid), 32'd1);
        drain();

        // Subtraction to zero, then an add with exponent difference
        setr(2, 32'h40000000, 32'h40000000, FP_OP_SUB);
        push(2, 32'h00000000);
        grant("sub_g", 4'b0100);
        req_valid[2] = 1'b0;
        drain();
        setr(2, 32'h40000000, 32'h43800000, FP_OP_ADD);
        push(2, 32'h43810000);
        grant("add_g", 4'b0100);
        req_valid[2] = 1'b0;
        drain();

        // Back-pressure for 5 cycles in RESP with new requests waiting
        rsp_ready = 1'b0;
        setr(1, 32'h40000000, 32'h3F800000, FP_OP_ADD);
        push(1, 32'h40400000);
        grant("bp_g", 4'b0010);
        req_valid[1] = 1'b0;
        tick(1);
        setr(3, 32'h40800000, 32'h3F800000, FP_OP_ADD);
        setr(1, 32'h3F800000, 32'h3F800000, FP_OP_ADD);
        push(3, 32'h40A00000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_vld", 32'(rsp_valid), 32'd1);
            chk("bp_data", rsp_data, 32'h40400000);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_rdy", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
`ifdef FP_ARB_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'd5);
`endif
        rsp_ready = 1'b1;

        // Requester 1 withdraws while requester 3 is served
        grant("wd_g3", 4'b1000);
        req_valid[3] = 1'b0;
        req_valid[1] = 1'b0;
        drain();
        tick(4);
        @(negedge clk);
        chk("wd_rdy", 32'(req_ready), 32'd0);
        tick(1);

        // Move rr_ptr to 2, then reset during EXEC of requester 2
        setr(1, 32'h40000000, 32'h40000000, FP_OP_ADD);
        push(1, 32'h40800000);
        grant("pre_g", 4'b0010);
        req_valid[1] = 1'b0;
        drain();
        setr(2, 32'h3F800000, 32'h3F800000, FP_OP_ADD);
        grant("rst_g", 4'b0100);
        req_valid[2] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_vld", 32'(rsp_valid), 32'd0);
        chk("midrst_data", rsp_data, 32'd0);
        chk("midrst_id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(2);
        @(negedge clk);
        chk("postrst_vld", 32'(rsp_valid), 32'd0);
        tick(1);
        setr(0, 32'h40000000, 32'h43800000, FP_OP_ADD);
        push(0, 32'h43810000);
        setr(2, 32'h40400000, 32'h3F800000, FP_OP_SUB);
        push(2, 32'h40000000);
        grant("post_g0", 4'b0001);
        req_valid[0] = 1'b0;
        grant("post_g2", 4'b0100);
        req_valid[2] = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
